// File: rtl/tag_release_unit_if.sv
// Bundle of the allocation, completion, release and status signals of
// tag_release_unit. The master side is the dispatcher/writeback environment,
// the slave side is the release unit itself.
interface tag_release_unit_if #(
    parameter int NumTags  = 16,
    parameter int NumAlloc = 2,
    parameter int NumDone  = 2,
    parameter int NumFree  = 2
);
    localparam int TagWidth = $clog2(NumTags);

    logic [NumAlloc-1:0]          alloc_i;
    logic [NumAlloc*TagWidth-1:0] alloc_tag_i;
    logic [NumDone-1:0]           done_i;
    logic [NumDone*TagWidth-1:0]  done_tag_i;
    logic [NumFree-1:0]           free_o;
    logic [NumFree*TagWidth-1:0]  free_tag_o;
    logic [NumTags-1:0]           pending_o;
    logic                         idle_o;
    logic                         error_o;

    modport master (
        output alloc_i, alloc_tag_i, done_i, done_tag_i,
        input  free_o, free_tag_o, pending_o, idle_o, error_o
    );

    modport slave (
        input  alloc_i, alloc_tag_i, done_i, done_tag_i,
        output free_o, free_tag_o, pending_o, idle_o, error_o
    );
endinterface

// File: rtl/tag_release_unit.sv
// tag_release_unit: tracks every tag handed out by tag_queue from allocation
// to completion and hands completed tags back on tag_queue's free port.
// Default build releases DONE tags round-robin from a rotating pointer.
// Defining TAG_RELEASE_ORDERED_EN swaps the pointer for an allocation-order
// FIFO so tags are returned in the order they were handed out.
// Modulo arithmetic on tag indices is done in int so NumTags need not be a
// power of two.
module tag_release_unit #(
    parameter int NumTags  = 16,
    parameter int NumAlloc = 2,
    parameter int NumDone  = 2,
    parameter int NumFree  = 2
) (
    input logic               clk_i,
    input logic               rst_i,
    tag_release_unit_if.slave bus
);
    localparam int TagWidth   = $clog2(NumTags);
    localparam int CountWidth = $clog2(NumTags + 1);

    typedef enum logic [1:0] {
        TAG_FREE      = 2'd0,
        TAG_ALLOCATED = 2'd1,
        TAG_DONE      = 2'd2
    } tag_state_e;

    tag_state_e          state_q   [NumTags];
    logic [TagWidth-1:0] alloc_tag [NumAlloc];
    logic [TagWidth-1:0] done_tag  [NumDone];
    logic [TagWidth-1:0] pick_tag  [NumFree];
    logic [NumAlloc-1:0] alloc_pre;
    logic [NumAlloc-1:0] alloc_ok;
    logic [NumDone-1:0]  done_ok;
    logic [NumFree-1:0]  pick_valid;
    logic [NumTags-1:0]  pending;
    logic                event_error;

    // Split the flat tag buses into per-port tags
    always_comb begin
        for (int p = 0; p < NumAlloc; p++) alloc_tag[p] = bus.alloc_tag_i[p*TagWidth +: TagWidth];
        for (int d = 0; d < NumDone; d++)  done_tag[d]  = bus.done_tag_i[d*TagWidth +: TagWidth];
    end

    // Qualify each event; any clash on a tag kills every event involved
    always_comb begin
        for (int p = 0; p < NumAlloc; p++) begin
            alloc_pre[p] = bus.alloc_i[p] && (state_q[alloc_tag[p]] == TAG_FREE);
            for (int q = 0; q < NumAlloc; q++)
                if (q != p && bus.alloc_i[q] && alloc_tag[q] == alloc_tag[p]) alloc_pre[p] = 1'b0;
            for (int d = 0; d < NumDone; d++)
                if (bus.done_i[d] && done_tag[d] == alloc_tag[p]) alloc_pre[p] = 1'b0;
        end
        for (int d = 0; d < NumDone; d++) begin
            done_ok[d] = bus.done_i[d] && (state_q[done_tag[d]] == TAG_ALLOCATED);
            for (int e = 0; e < NumDone; e++)
                if (e != d && bus.done_i[e] && done_tag[e] == done_tag[d]) done_ok[d] = 1'b0;
            for (int p = 0; p < NumAlloc; p++)
                if (bus.alloc_i[p] && alloc_tag[p] == done_tag[d]) done_ok[d] = 1'b0;
        end
    end

`ifndef TAG_RELEASE_ORDERED_EN
    logic [TagWidth-1:0] ptr_q;
    logic [TagWidth-1:0] ptr_next;

    assign alloc_ok = alloc_pre;

    // Pick the first NumFree DONE tags scanning upward from the pointer
    always_comb begin
        int                  cnt;
        logic                taken;
        logic [TagWidth-1:0] idx;
        cnt        = 0;
        pick_valid = '0;
        ptr_next   = ptr_q;
        for (int k = 0; k < NumFree; k++) pick_tag[k] = '0;
        for (int i = 0; i < NumTags; i++) begin
            idx   = TagWidth'((int'(ptr_q) + i) % NumTags);
            taken = 1'b0;
            if (state_q[idx] == TAG_DONE) begin
                for (int k = 0; k < NumFree; k++) begin
                    if (!taken && cnt == k) begin
                        pick_valid[k] = 1'b1;
                        pick_tag[k]   = idx;
                        taken         = 1'b1;
                    end
                end
            end
            if (taken) begin
                cnt      = cnt + 1;
                ptr_next = TagWidth'((int'(idx) + 1) % NumTags);
            end
        end
    end

    // Pointer moves just past the last tag released
    always_ff @(posedge clk_i) begin
        if (rst_i) ptr_q <= '0;
        else       ptr_q <= ptr_next;
    end
`else
    logic [TagWidth-1:0]   fifo_q [NumTags];
    logic [TagWidth-1:0]   push_slot [NumAlloc];
    logic [TagWidth-1:0]   head_q;
    logic [CountWidth-1:0] count_q;
    logic [CountWidth-1:0] pop_count;
    logic [CountWidth-1:0] push_count;

    // Release consecutive DONE entries at the FIFO head, stopping at the first that is not DONE
    always_comb begin
        logic                stop;
        logic [TagWidth-1:0] pos;
        stop       = 1'b0;
        pop_count  = '0;
        pick_valid = '0;
        for (int k = 0; k < NumFree; k++) begin
            pick_tag[k] = '0;
            pos         = TagWidth'((int'(head_q) + k) % NumTags);
            if (!stop && k < int'(count_q) && state_q[fifo_q[pos]] == TAG_DONE) begin
                pick_valid[k] = 1'b1;
                pick_tag[k]   = fifo_q[pos];
                pop_count     = pop_count + CountWidth'(1);
            end else begin
                stop = 1'b1;
            end
        end
    end

    // Accept allocations in port order while FIFO space remains; an overflowing alloc is dropped
    always_comb begin
        int space;
        space      = NumTags - int'(count_q) + int'(pop_count);
        push_count = '0;
        for (int p = 0; p < NumAlloc; p++) begin
            alloc_ok[p]  = alloc_pre[p];
            push_slot[p] = TagWidth'((int'(head_q) + int'(count_q) + int'(push_count)) % NumTags);
            if (alloc_pre[p]) begin
                if (int'(push_count) < space) push_count = push_count + CountWidth'(1);
                else                          alloc_ok[p] = 1'b0;
            end
        end
    end

    // Advance head past released entries and append newly allocated tags at the tail
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            head_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= TagWidth'((int'(head_q) + int'(pop_count)) % NumTags);
            count_q <= count_q - pop_count + push_count;
            for (int p = 0; p < NumAlloc; p++)
                if (alloc_ok[p]) fifo_q[push_slot[p]] <= alloc_tag[p];
        end
    end
`endif

    assign event_error = (|(bus.alloc_i & ~alloc_ok)) | (|(bus.done_i & ~done_ok));

    // Per-tag state update, registered release outputs and sticky error flag
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int t = 0; t < NumTags; t++) state_q[t] <= TAG_FREE;
            bus.free_o     <= '0;
            bus.free_tag_o <= '0;
            bus.error_o    <= 1'b0;
        end else begin
            for (int k = 0; k < NumFree; k++)
                if (pick_valid[k]) state_q[pick_tag[k]] <= TAG_FREE;
            for (int p = 0; p < NumAlloc; p++)
                if (alloc_ok[p]) state_q[alloc_tag[p]] <= TAG_ALLOCATED;
            for (int d = 0; d < NumDone; d++)
                if (done_ok[d]) state_q[done_tag[d]] <= TAG_DONE;
            bus.free_o <= pick_valid;
            for (int k = 0; k < NumFree; k++)
                bus.free_tag_o[k*TagWidth +: TagWidth] <= pick_tag[k];
            if (event_error) bus.error_o <= 1'b1;
        end
    end

    // Status views derived straight from the state array
    always_comb begin
        for (int t = 0; t < NumTags; t++) pending[t] = (state_q[t] != TAG_FREE);
    end

    assign bus.pending_o = pending;
    assign bus.idle_o    = ~|pending;
endmodule

// File: tb/tb_tag_release_unit.sv
// Directed testbench for tag_release_unit with a release scoreboard.
// The unit is built with three completion ports so three tags can reach
// DONE together, which is what the wrap-around release case needs.
module tb_tag_release_unit;
    localparam int NumTags  = 16;
    localparam int NumAlloc = 2;
    localparam int NumDone  = 3;
    localparam int NumFree  = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       mon_en = 1'b0;
    logic [3:0] expect_q [$];
    int         n_vec  = 0;
    int         n_miss = 0;

    tag_release_unit_if #(
        .NumTags(NumTags), .NumAlloc(NumAlloc), .NumDone(NumDone), .NumFree(NumFree)
    ) bus ();

    tag_release_unit #(
        .NumTags(NumTags), .NumAlloc(NumAlloc), .NumDone(NumDone), .NumFree(NumFree)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_vec++;
        if (actual !== expected) begin
            n_miss++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Drive one cycle of events, let the edge happen, then clear the inputs
    task automatic apply_stimulus(input logic [1:0] a, input logic [3:0] at0, input logic [3:0] at1,
                                  input logic [2:0] d, input logic [3:0] dt0, input logic [3:0] dt1,
                                  input logic [3:0] dt2);
        @(negedge clk);
        bus.alloc_i     = a;
        bus.alloc_tag_i = {at1, at0};
        bus.done_i      = d;
        bus.done_tag_i  = {dt2, dt1, dt0};
        @(posedge clk);
        #1;
        bus.alloc_i = '0;
        bus.done_i  = '0;
    endtask

    task automatic idle_cycle();
        apply_stimulus(2'b00, 4'd0, 4'd0, 3'b000, 4'd0, 4'd0, 4'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Monitor: every release strobe must match the next expected tag in order
    always @(negedge clk) begin
        if (mon_en) begin
            for (int k = 0; k < NumFree; k++) begin
                if (bus.free_o[k] === 1'b1) begin
                    if (expect_q.size() == 0) begin
                        check_output("unexpected_release", {28'd0, bus.free_tag_o[k*4 +: 4]}, 32'hFFFF_FFFF);
                    end else begin
                        check_output("release_tag", {28'd0, bus.free_tag_o[k*4 +: 4]}, {28'd0, expect_q.pop_front()});
                    end
                end else begin
                    check_output("unused_port_tag", {28'd0, bus.free_tag_o[k*4 +: 4]}, 32'd0);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bus.alloc_i     = '0;
        bus.alloc_tag_i = '0;
        bus.done_i      = '0;
        bus.done_tag_i  = '0;

        // Reset held three cycles while events toggle
        rst = 1'b1;
        apply_stimulus(2'b11, 4'd1, 4'd2, 3'b000, 4'd0, 4'd0, 4'd0);
        apply_stimulus(2'b01, 4'd9, 4'd0, 3'b011, 4'd1, 4'd2, 4'd0);
        apply_stimulus(2'b10, 4'd0, 4'd4, 3'b101, 4'd4, 4'd0, 4'd9);
        check_output("reset_free", {30'd0, bus.free_o}, 32'd0);
        check_output("reset_pending", {16'd0, bus.pending_o}, 32'd0);
        check_output("reset_idle", {31'd0, bus.idle_o}, 32'd1);
        check_output("reset_error", {31'd0, bus.error_o}, 32'd0);
        rst    = 1'b0;
        mon_en = 1'b1;

        // Single tag: alloc 5, done 5 two edges later, release right after the next edge
        apply_stimulus(2'b01, 4'd5, 4'd0, 3'b000, 4'd0, 4'd0, 4'd0);
        check_output("single_pending_alloc", {16'd0, bus.pending_o}, 32'h0020);
        check_output("single_idle_alloc", {31'd0, bus.idle_o}, 32'd0);
        idle_cycle();
        expect_q.push_back(4'd5);
        apply_stimulus(2'b00, 4'd0, 4'd0, 3'b001, 4'd5, 4'd0, 4'd0);
        check_output("single_free_early", {30'd0, bus.free_o}, 32'd0);
        check_output("single_pending_done", {16'd0, bus.pending_o}, 32'h0020);
        idle_cycle();
        check_output("single_free", {30'd0, bus.free_o}, 32'd1);
        check_output("single_free_tag", {24'd0, bus.free_tag_o}, 32'h05);
        check_output("single_pending_rel", {16'd0, bus.pending_o}, 32'd0);
        check_output("single_idle_rel", {31'd0, bus.idle_o}, 32'd1);
        idle_cycle();
        check_output("single_free_drop", {30'd0, bus.free_o}, 32'd0);

        // Burst from pointer 0: two releases per cycle in order 0..5
        do_reset();
        apply_stimulus(2'b11, 4'd0, 4'd1, 3'b000, 4'd0, 4'd0, 4'd0);
        apply_stimulus(2'b11, 4'd2, 4'd3, 3'b000, 4'd0, 4'd0, 4'd0);
        apply_stimulus(2'b11, 4'd4, 4'd5, 3'b000, 4'd0, 4'd0, 4'd0);
        check_output("burst_pending", {16'd0, bus.pending_o}, 32'h003F);
        for (int t = 0; t < 6; t++) expect_q.push_back(4'(t));
        apply_stimulus(2'b00, 4'd0, 4'd0, 3'b011, 4'd0, 4'd1, 4'd0);
        apply_stimulus(2'b00, 4'd0, 4'd0, 3'b011, 4'd2, 4'd3, 4'd0);
        check_output("burst_free_a", {30'd0, bus.free_o}, 32'd3);
        check_output("burst_tags_a", {24'd0, bus.free_tag_o}, 32'h10);
        apply_stimulus(2'b00, 4'd0, 4'd0, 3'b011, 4'd4, 4'd5, 4'd0);
        check_output("burst_free_b", {30'd0, bus.free_o}, 32'd3);
        check_output("burst_tags_b", {24'd0, bus.free_tag_o}, 32'h32);
        idle_cycle();
        check_output("burst_free_c", {30'd0, bus.free_o}, 32'd3);
        check_output("burst_tags_c", {24'd0, bus.free_tag_o}, 32'h54);
        idle_cycle();
        check_output("burst_free_end", {30'd0, bus.free_o}, 32'd0);
        check_output("burst_idle", {31'd0, bus.idle_o}, 32'd1);

        // Pointer is 6; releasing tag 13 moves it to 14
        apply_stimulus(2'b01, 4'd13, 4'd0, 3'b000, 4'd0, 4'd0, 4'd0);
        expect_q.push_back(4'd13);
        apply_stimulus(2'b00, 4'd0, 4'd0, 3'b001, 4'd13, 4'd0, 4'd0);
        idle_cycle();
        idle_cycle();

        // Wrap-around: DONE {1,14,15} from pointer 14 releases 14,15 then 1
        apply_stimulus(2'b11, 4'd1, 4'd14, 3'b000, 4'd0, 4'd0, 4'd0);
        apply_stimulus(2'b01, 4'd15, 4'd0, 3'b000, 4'd0, 4'd0, 4'd0);
        expect_q.push_back(4'd14);
        expect_q.push_back(4'd15);
        expect_q.push_back(4'd1);
        apply_stimulus(2'b00, 4'd0, 4'd0, 3'b111, 4'd1, 4'd14, 4'd15);
        idle_cycle();
        check_output("wrap_free_a", {30'd0, bus.free_o}, 32'd3);
        check_output("wrap_tags_a", {24'd0, bus.free_tag_o}, 32'hFE);
        idle_cycle();
        check_output("wrap_free_b", {30'd0, bus.free_o}, 32'd1);
        check_output("wrap_tags_b", {24'd0, bus.free_tag_o}, 32'h01);
        idle_cycle();

        // Pointer now 2: DONE {0,3} must come out as 3 then 0
        apply_stimulus(2'b11, 4'd0, 4'd3, 3'b000, 4'd0, 4'd0, 4'd0);
        expect_q.push_back(4'd3);
        expect_q.push_back(4'd0);
        apply_stimulus(2'b00, 4'd0, 4'd0, 3'b011, 4'd0, 4'd3, 4'd0);
        idle_cycle();
        check_output("ptr2_tags", {24'd0, bus.free_tag_o}, 32'h03);
        idle_cycle();
        check_output("ptr2_error", {31'd0, bus.error_o}, 32'd0);

        // Error: alloc tag 3 twice; tag stays ALLOCATED and still completes normally
        do_reset();
        apply_stimulus(2'b01, 4'd3, 4'd0, 3'b000, 4'd0, 4'd0, 4'd0);
        check_output("err_realloc_pre", {31'd0, bus.error_o}, 32'd0);
        apply_stimulus(2'b01, 4'd3, 4'd0, 3'b000, 4'd0, 4'd0, 4'd0);
        check_output("err_realloc_flag", {31'd0, bus.error_o}, 32'd1);
        check_output("err_realloc_pending", {16'd0, bus.pending_o}, 32'h0008);
        expect_q.push_back(4'd3);
        apply_stimulus(2'b00, 4'd0, 4'd0, 3'b001, 4'd3, 4'd0, 4'd0);
        idle_cycle();
        idle_cycle();
        check_output("err_realloc_drain", {16'd0, bus.pending_o}, 32'd0);
        check_output("err_sticky", {31'd0, bus.error_o}, 32'd1);

        // Error: done of a FREE tag
        do_reset();
        check_output("err_done_free_pre", {31'd0, bus.error_o}, 32'd0);
        apply_stimulus(2'b00, 4'd0, 4'd0, 3'b001, 4'd7, 4'd0, 4'd0);
        check_output("err_done_free_flag", {31'd0, bus.error_o}, 32'd1);
        check_output("err_done_free_pending", {16'd0, bus.pending_o}, 32'd0);
        idle_cycle();
        check_output("err_done_free_norel", {30'd0, bus.free_o}, 32'd0);

        // Error: alloc and done of tag 2 together
        do_reset();
        apply_stimulus(2'b01, 4'd2, 4'd0, 3'b001, 4'd2, 4'd0, 4'd0);
        check_output("err_same_flag", {31'd0, bus.error_o}, 32'd1);
        check_output("err_same_pending", {16'd0, bus.pending_o}, 32'd0);

        // Error: one tag on both alloc ports
        do_reset();
        apply_stimulus(2'b11, 4'd4, 4'd4, 3'b000, 4'd0, 4'd0, 4'd0);
        check_output("err_dup_alloc_flag", {31'd0, bus.error_o}, 32'd1);
        check_output("err_dup_alloc_pending", {16'd0, bus.pending_o}, 32'd0);

        // Error: one tag on two done ports; tag stays ALLOCATED and is never released
        do_reset();
        apply_stimulus(2'b01, 4'd6, 4'd0, 3'b000, 4'd0, 4'd0, 4'd0);
        apply_stimulus(2'b00, 4'd0, 4'd0, 3'b011, 4'd6, 4'd6, 4'd0);
        check_output("err_dup_done_flag", {31'd0, bus.error_o}, 32'd1);
        check_output("err_dup_done_pending", {16'd0, bus.pending_o}, 32'h0040);
        idle_cycle();
        idle_cycle();

        check_output("scoreboard_empty", expect_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
